// File: rtl/mult_div.sv
// mult_div: multiply/divide unit with HI/LO result registers.
//   MULT/MULTU run 5 cycles, DIV/DIVU run 10 cycles. The result lands in
//   HI/LO on the edge at which Busy falls. MTHI/MTLO write A into HI/LO
//   at once and never set Busy.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset
//   A, B   - operands (rs, rt), latched when a long operation starts
//   MDUOp  - 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, others no-op
//   Start  - qualifies MDUOp for one cycle; ignored while Busy
//   Busy   - multiply or divide in progress
//   HI, LO - result registers
// Build option: define MDU_DIV_EN to include the divider. Without it,
//   DIV/DIVU codes behave as no-ops.
module mult_div (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned W       = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned MUL_LAT = 5;

    localparam logic [OP_W-1:0] OP_MULT  = 4'b0001;
    localparam logic [OP_W-1:0] OP_MULTU = 4'b0010;
    localparam logic [OP_W-1:0] OP_MTHI  = 4'b0101;
    localparam logic [OP_W-1:0] OP_MTLO  = 4'b0110;
`ifdef MDU_DIV_EN
    localparam int unsigned     DIV_LAT  = 10;
    localparam logic [OP_W-1:0] OP_DIV   = 4'b0011;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'b0100;
`endif

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           state, state_n;
    logic [W-1:0]     a_q, b_q, a_n, b_n;
    logic [OP_W-1:0]  op_q, op_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [W-1:0]     hi_n, lo_n;

    // Multiplier: extend per signedness, keep the low 2W bits of the product.
    logic             mul_signed, is_mul;
    logic [2*W-1:0]   mul_a, mul_b, prod;

    assign mul_signed = (op_q == OP_MULT);
    assign is_mul     = (op_q == OP_MULT) || (op_q == OP_MULTU);
    assign mul_a      = mul_signed ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    assign mul_b      = mul_signed ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
    assign prod       = mul_a * mul_b;

`ifdef MDU_DIV_EN
    // Divider: unsigned divide of magnitudes, then restore signs.
    // 0x80000000 / -1 falls out naturally: magnitude 2^31 negates to itself.
    logic         div_signed, a_neg, b_neg, div_zero;
    logic [W-1:0] a_mag, b_mag, b_safe, q_mag, r_mag, div_quo, div_rem;

    assign div_signed = (op_q == OP_DIV);
    assign a_neg      = div_signed & a_q[W-1];
    assign b_neg      = div_signed & b_q[W-1];
    assign a_mag      = a_neg ? (W'(0) - a_q) : a_q;
    assign b_mag      = b_neg ? (W'(0) - b_q) : b_q;
    assign div_zero   = (b_q == W'(0));
    assign b_safe     = div_zero ? W'(1) : b_mag;
    assign q_mag      = a_mag / b_safe;
    assign r_mag      = a_mag % b_safe;
    assign div_quo    = (a_neg ^ b_neg) ? (W'(0) - q_mag) : q_mag;
    assign div_rem    = a_neg ? (W'(0) - r_mag) : r_mag;
`endif

    assign Busy = (state == S_BUSY);

    // Next-state: accept ops in idle, count down while busy, commit on last cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = a_q;
        b_n     = b_q;
        op_n    = op_q;
        hi_n    = HI;
        lo_n    = LO;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    case (MDUOp)
                        OP_MULT, OP_MULTU: begin
                            a_n     = A;
                            b_n     = B;
                            op_n    = MDUOp;
                            cnt_n   = CNT_W'(MUL_LAT);
                            state_n = S_BUSY;
                        end
`ifdef MDU_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            a_n     = A;
                            b_n     = B;
                            op_n    = MDUOp;
                            cnt_n   = CNT_W'(DIV_LAT);
                            state_n = S_BUSY;
                        end
`endif
                        OP_MTHI: hi_n = A;
                        OP_MTLO: lo_n = A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = S_IDLE;
                    if (is_mul) begin
                        hi_n = prod[2*W-1:W];
                        lo_n = prod[W-1:0];
                    end
`ifdef MDU_DIV_EN
                    else if (!div_zero) begin
                        hi_n = div_rem;
                        lo_n = div_quo;
                    end
`endif
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            a_q   <= a_n;
            b_q   <= b_n;
            op_q  <= op_n;
            HI    <= hi_n;
            LO    <= lo_n;
        end
    end

endmodule
